nanov_io_periph: RTL
====================

// Module: nanov_io_periph
// PURPOSE
//  Memory-mapped peripheral block downstream of the nanoV CPU's external data port. Decodes
//  loads/stores whose address has bits [31:24] != 0. Provides a GPIO output/input register
//  pair, an 8N1 UART with a TX FIFO and a one-byte RX buffer, and an optional timer.
//  It supplies ext_data_in for loads and consumes the CPU's addr/data strobes.
// PARAMETERS
//  CLOCK_DIV      104  UART bit period in clk cycles (>=4)
//  TX_FIFO_DEPTH  4    TX FIFO entries, power of two (2..16)
//  GPIO_WIDTH     8    width of gpio_out / gpio_in (1..32)
// PORTS
//  clk             in   1           single clock; all state on posedge
//  rst             in   1           synchronous reset, active-high
//  data_out        in   32          CPU data_out: address or bit-reversed store data
//  store_addr_out  in   1           data_out holds a load/store address this cycle
//  store_data_out  in   1           data_out holds bit-reversed store data this cycle
//  data_in_read    in   1           CPU has consumed ext_data_in for a load
//  ext_data_in     out  32          load data for the selected register
//  gpio_out        out  GPIO_WIDTH  GPIO output register
//  gpio_in         in   GPIO_WIDTH  GPIO inputs (async; 2-flop synchronised)
//  uart_txd        out  1           UART transmit line, idle high
//  uart_rxd        in   1           UART receive line (async; 2-flop synchronised)
// BEHAVIOUR
//  Reset: ext_data_in=0, gpio_out=0, uart_txd=1, FIFO empty, rx_valid=0, sticky flags=0, sel=0.
//  Decode: on store_addr_out, sel <= (data_out[31:24]!=0); if set, addr <= data_out[4:2].
//  Map (byte addr low bits): 0x00 GPIO_OUT rw | 0x04 GPIO_IN ro | 0x08 UART_DATA
//   (w: push TX, r: RX byte in [7:0]) | 0x0C STATUS ro | 0x10 TIMER | others read 0, write ignored.
//  STATUS: [0] tx_full [1] rx_valid [2] tx_busy (FIFO non-empty or frame active)
//   [3] tx_overflow sticky [4] rx_overrun sticky [5] rx_frame_err sticky; [3..5] clear when
//   a load of STATUS completes (data_in_read).
//  Load: ext_data_in snapshotted 1 cycle after store_addr_out; held constant until the next
//   store_addr_out. Not-selected address -> ext_data_in=0.
//  Store: on store_data_out && sel, wdata = bit-reverse(data_out); write takes effect same edge.
//  data_in_read && sel && addr==UART_DATA: rx_valid <= 0 (pop). sel clears on store_data_out
//   or data_in_read; strobes while sel=0 have no side effects.
//  TX FIFO: push on UART_DATA write; full and no pop same cycle -> drop byte, set tx_overflow;
//   full with simultaneous pop -> push accepted. Pointers wrap modulo depth.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each state/bit CLOCK_DIV clks;
//   pop on IDLE->START; back-to-back bytes with no idle gap.
//  RX FSM IDLE->START->DATA->STOP: falling edge of synced rxd enters START; sample at
//   CLOCK_DIV/2, start=1 at midpoint -> IDLE (glitch). STOP sample 0 -> discard, set
//   rx_frame_err. Good byte with rx_valid=1 and no same-cycle pop -> overwrite, set
//   rx_overrun; same-cycle pop -> new byte stored, rx_valid stays 1, no overrun.
//  rst mid-frame: uart_txd=1 next cycle, FIFO/frames discarded, no partial byte kept.
// CONFIGURATION
//  NANOV_IO_TIMER_EN defined: 32-bit free-running up-counter at 0x10, +1 every clk, wraps
//   0xFFFFFFFF->0; store loads wdata (counts from wdata next cycle); reset to 0.
//  Undefined: no timer logic; 0x10 reads 0, writes ignored.
// TESTING
//  Store 0xA5 to 0x10000000 (data_out=bitrev) -> gpio_out=0xA5 same edge; load reads 0x000000A5.
//  Store 0x55 to 0x10000008, CLOCK_DIV=8 -> txd: 0 for 8 clks, 1,0,1,0,1,0,1,0 then 1; tx_busy low after.
//  5 stores to UART_DATA with depth 4 while TX active -> 4 bytes sent in order, STATUS[3]=1,
//   cleared after STATUS load.
//  Drive rxd frame 0x3C -> STATUS[1]=1; load UART_DATA -> 0x3C, STATUS[1]=0; second frame
//   unread then third -> STATUS[4]=1, data=third byte.
//  Address 0x00001000 + store_data_out -> no register change, ext_data_in=0.
//  Timer (macro on): store 0xFFFFFFFE, load 3 clks later -> wrapped value; macro off -> reads 0.

Source files
------------

// File: rtl/nanov_io_periph.sv
// nanov_io_periph: GPIO, 8N1 UART (TX FIFO, 1-byte RX buffer) and optional timer on the nanoV
// external data port. Define NANOV_IO_TIMER_EN to build the 32-bit timer at offset 0x10.
module nanov_io_periph #(
    parameter int unsigned CLOCK_DIV     = 104,
    parameter int unsigned TX_FIFO_DEPTH = 4,
    parameter int unsigned GPIO_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_out,
    input  logic                  store_addr_out,
    input  logic                  store_data_out,
    input  logic                  data_in_read,
    output logic [31:0]           ext_data_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic                  uart_txd,
    input  logic                  uart_rxd
);
    localparam int unsigned PtrW   = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned CntW   = $clog2(CLOCK_DIV);
    localparam logic [CntW-1:0]   DivLast  = CntW'(CLOCK_DIV - 1);
    localparam logic [CntW-1:0]   HalfLast = CntW'(CLOCK_DIV / 2 - 1);
    localparam logic [CountW-1:0] FifoFull = CountW'(TX_FIFO_DEPTH);

    localparam logic [2:0] AddrGpioOut  = 3'd0;
    localparam logic [2:0] AddrGpioIn   = 3'd1;
    localparam logic [2:0] AddrUartData = 3'd2;
    localparam logic [2:0] AddrStatus   = 3'd3;
    localparam logic [2:0] AddrTimer    = 3'd4;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Bus decode and load snapshot
    logic        sel_q, snap_q;
    logic [2:0]  addr_q;
    logic [31:0] ext_data_q, rdata, wdata, timer_rd;
    logic        wr_en, rd_done, rx_pop, stat_clr;

    assign wdata    = bitrev(data_out);
    assign wr_en    = store_data_out & sel_q;
    assign rd_done  = data_in_read & sel_q;
    assign rx_pop   = rd_done && (addr_q == AddrUartData);
    assign stat_clr = rd_done && (addr_q == AddrStatus);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= 1'b0;
            snap_q     <= 1'b0;
            addr_q     <= '0;
            ext_data_q <= '0;
        end else begin
            snap_q <= store_addr_out;
            if (store_addr_out) begin
                sel_q <= |data_out[31:24];
                if (|data_out[31:24]) addr_q <= data_out[4:2];
            end else if (store_data_out || data_in_read) begin
                sel_q <= 1'b0;
            end
            if (snap_q) ext_data_q <= sel_q ? rdata : '0;
        end
    end

    // GPIO and synchronisers
    logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_s1_q, gpio_s2_q;
    logic                  rxd_s1_q, rxd_s2_q, rxd_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            gpio_s1_q  <= gpio_in;
            gpio_s2_q  <= gpio_s1_q;
            rxd_s1_q   <= uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    // TX FIFO
    logic [7:0]        fifo_mem [TX_FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CountW-1:0] count_q;
    logic              push_req, push, pop, tx_full, tx_busy, tx_slot_end;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    tx_state_e       tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            txd_q;

    assign tx_full     = (count_q == FifoFull);
    assign tx_busy     = (count_q != '0) || (tx_state_q != TxIdle);
    assign tx_slot_end = (tx_cnt_q == DivLast);
    assign push_req    = wr_en && (addr_q == AddrUartData);
    assign pop         = (count_q != '0) &&
                         ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && tx_slot_end));
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push        = push_req && (!tx_full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_cnt_q <= tx_slot_end ? '0 : tx_cnt_q + 1'b1;
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q <= '0;
                    if (pop) begin
                        tx_state_q <= TxStart;
                        tx_shift_q <= fifo_mem[rptr_q];
                        txd_q      <= 1'b0;
                    end
                end
                TxStart: if (tx_slot_end) begin
                    tx_state_q <= TxData;
                    tx_bit_q   <= '0;
                    txd_q      <= tx_shift_q[0];
                end
                TxData: if (tx_slot_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TxStop;
                        txd_q      <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_shift_q <= tx_shift_q >> 1;
                        txd_q      <= tx_shift_q[1];
                    end
                end
                TxStop: if (tx_slot_end) begin
                    if (pop) begin
                        tx_state_q <= TxStart;
                        tx_shift_q <= fifo_mem[rptr_q];
                        txd_q      <= 1'b0;
                    end else begin
                        tx_state_q <= TxIdle;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // RX FSM; emits one-cycle done / bad-stop pulses to the register block
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    rx_state_e       rx_state_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_done_q, rx_bad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_bad_q  <= 1'b0;
            rx_cnt_q  <= rx_cnt_q + 1'b1;
            unique case (rx_state_q)
                RxIdle: begin
                    rx_cnt_q <= '0;
                    if (rxd_prev_q && !rxd_s2_q) rx_state_q <= RxStart;
                end
                RxStart: if (rx_cnt_q == HalfLast) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rxd_s2_q ? RxIdle : RxData;
                end
                RxData: if (rx_cnt_q == DivLast) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                end
                RxStop: if (rx_cnt_q == DivLast) begin
                    rx_state_q <= RxIdle;
                    rx_done_q  <= rxd_s2_q;
                    rx_bad_q   <= !rxd_s2_q;
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Register file: GPIO out, RX buffer, sticky status
    logic       rx_valid_q, tx_ovf_q, rx_ovr_q, rx_ferr_q;
    logic [7:0] rx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            if (wr_en && (addr_q == AddrGpioOut)) gpio_out_q <= wdata[GPIO_WIDTH-1:0];
            if (rx_done_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_q <= 1'b0;
            end
            if (push_req && tx_full && !pop)         tx_ovf_q  <= 1'b1;
            else if (stat_clr)                       tx_ovf_q  <= 1'b0;
            if (rx_done_q && rx_valid_q && !rx_pop)  rx_ovr_q  <= 1'b1;
            else if (stat_clr)                       rx_ovr_q  <= 1'b0;
            if (rx_bad_q)                            rx_ferr_q <= 1'b1;
            else if (stat_clr)                       rx_ferr_q <= 1'b0;
        end
    end

`ifdef NANOV_IO_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clk) begin
        if (rst)                                   timer_q <= '0;
        else if (wr_en && (addr_q == AddrTimer))   timer_q <= wdata;
        else                                       timer_q <= timer_q + 1'b1;
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        unique case (addr_q)
            AddrGpioOut:  rdata = 32'(gpio_out_q);
            AddrGpioIn:   rdata = 32'(gpio_s2_q);
            AddrUartData: rdata = {24'b0, rx_data_q};
            AddrStatus:   rdata = {26'b0, rx_ferr_q, rx_ovr_q, tx_ovf_q, tx_busy, rx_valid_q,
                                   tx_full};
            AddrTimer:    rdata = timer_rd;
            default:      rdata = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{data_out[23:5], data_out[1:0], wdata};

    assign ext_data_in = ext_data_q;
    assign gpio_out    = gpio_out_q;
    assign uart_txd    = txd_q;

endmodule
